// File: rtl/rdma_pkt_builder_if.sv
// Bus bundle for rdma_pkt_builder: send request, payload stream in, frame stream out, status.
// The slave modport is the builder's view; master is the request/payload source and frame sink.
interface rdma_pkt_builder_if #(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8
);
    logic [63:0]           req_addr;
    logic [7:0]            req_beats;
    logic                  req_valid;
    logic                  req_ready;

    logic [DATA_WBITS-1:0] axis_pay_tdata;
    logic                  axis_pay_tlast;
    logic                  axis_pay_tvalid;
    logic                  axis_pay_tready;

    logic [DATA_WBITS-1:0] axis_out_tdata;
    logic [DATA_WBYTS-1:0] axis_out_tkeep;
    logic                  axis_out_tvalid;
    logic                  axis_out_tlast;
    logic                  axis_out_tready;

    logic                  len_err;
    logic [31:0]           pkt_count;

    modport master (
        output req_addr, req_beats, req_valid,
        input  req_ready,
        output axis_pay_tdata, axis_pay_tlast, axis_pay_tvalid,
        input  axis_pay_tready,
        input  axis_out_tdata, axis_out_tkeep, axis_out_tvalid, axis_out_tlast,
        output axis_out_tready,
        input  len_err, pkt_count
    );

    modport slave (
        input  req_addr, req_beats, req_valid,
        output req_ready,
        input  axis_pay_tdata, axis_pay_tlast, axis_pay_tvalid,
        output axis_pay_tready,
        output axis_out_tdata, axis_out_tkeep, axis_out_tvalid, axis_out_tlast,
        input  axis_out_tready,
        output len_err, pkt_count
    );
endinterface

// File: rtl/rdma_pkt_builder.sv
// RDMA transmit framer: one 64-byte Ethernet/IPv4/UDP/RDMA header beat followed by
// N payload beats passed through from the payload stream. Only a 512-bit datapath is supported.
module rdma_pkt_builder #(
    parameter int          DATA_WBITS     = 512,
    parameter int          DATA_WBYTS     = DATA_WBITS / 8,
    parameter logic [47:0] SRC_MAC        = 48'h02_00_00_00_00_02,
    parameter logic [47:0] DST_MAC        = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP         = 32'h0A01_0102,
    parameter logic [31:0] DST_IP         = 32'h0A01_0101,
    parameter logic [15:0] RDMA_SRC_PORT  = 16'd11111,
    parameter logic [15:0] RDMA_DEST_PORT = 16'd11111
) (
    input logic               clk,
    input logic               resetn,
    rdma_pkt_builder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StSendHdr, StSendData} state_e;

    localparam int HdrBytes = 64;

    state_e        state_q, state_d;
    logic [63:0]   addr_q;
    logic [7:0]    beats_q;
    logic [7:0]    cnt_q;
    logic [15:0]   ip_len_q, udp_len_q, csum_q, ip_id_q;
    logic          len_err_q;
    logic [31:0]   pkt_count_q;

    logic [15:0]   ip_len_calc, udp_len_calc;
    logic          req_fire, pay_fire, out_fire, last_beat;
    logic [511:0]  hdr_be;
    logic [DATA_WBITS-1:0] hdr;

    function automatic logic [15:0] ip_csum(input logic [15:0] len, input logic [15:0] id);
        logic [31:0] sum;
        sum = 32'h4500 + 32'h4000 + 32'h4011 + {16'h0, len} + {16'h0, id}
            + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
            + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
        // Nine 16-bit terms: two folds always leave the carry cleared.
        sum = {16'h0, sum[31:16]} + {16'h0, sum[15:0]};
        sum = {16'h0, sum[31:16]} + {16'h0, sum[15:0]};
        return ~sum[15:0];
    endfunction

    assign ip_len_calc  = 16'd50 + {2'b00, beats_q, 6'b000000};
    assign udp_len_calc = 16'd30 + {2'b00, beats_q, 6'b000000};
    assign last_beat    = (cnt_q == beats_q - 8'd1);

    // Header written big-endian as one vector, then byte-swapped onto the little-endian bus.
    assign hdr_be = {DST_MAC, SRC_MAC, 16'h0800,
                     16'h4500, ip_len_q, ip_id_q, 16'h4000, 16'h4011, csum_q, SRC_IP, DST_IP,
                     RDMA_SRC_PORT, RDMA_DEST_PORT, udp_len_q, 16'h0000,
                     addr_q, 112'h0};

    always_comb begin
        hdr = '0;
        for (int k = 0; k < HdrBytes; k++) begin
            hdr[8*k +: 8] = hdr_be[511 - 8*k -: 8];
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.req_ready       = 1'b0;
        bus.axis_pay_tready = 1'b0;
        bus.axis_out_tvalid = 1'b0;
        bus.axis_out_tlast  = 1'b0;
        bus.axis_out_tdata  = '0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = resetn;
                if (bus.req_valid && resetn) state_d = StCalc;
            end
            StCalc: state_d = StSendHdr;
            StSendHdr: begin
                bus.axis_out_tvalid = 1'b1;
                bus.axis_out_tdata  = hdr;
                bus.axis_out_tlast  = (beats_q == 8'd0);
                if (bus.axis_out_tready) begin
                    state_d = (beats_q == 8'd0) ? StIdle : StSendData;
                end
            end
            StSendData: begin
                bus.axis_out_tvalid = bus.axis_pay_tvalid;
                bus.axis_out_tdata  = bus.axis_pay_tdata;
                bus.axis_out_tlast  = last_beat;
                bus.axis_pay_tready = bus.axis_out_tready;
                if (bus.axis_pay_tvalid && bus.axis_out_tready && last_beat) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_fire = bus.req_valid & bus.req_ready;
    assign pay_fire = bus.axis_pay_tvalid & bus.axis_pay_tready;
    assign out_fire = bus.axis_out_tvalid & bus.axis_out_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            ip_len_q    <= '0;
            udp_len_q   <= '0;
            csum_q      <= '0;
            ip_id_q     <= '0;
            len_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q  <= bus.req_addr;
                beats_q <= bus.req_beats;
                cnt_q   <= '0;
            end
            if (state_q == StCalc) begin
                ip_len_q  <= ip_len_calc;
                udp_len_q <= udp_len_calc;
                csum_q    <= ip_csum(ip_len_calc, ip_id_q);
            end
            if (pay_fire) begin
                cnt_q <= cnt_q + 8'd1;
                if (bus.axis_pay_tlast != last_beat) len_err_q <= 1'b1;
            end
            if (out_fire && bus.axis_out_tlast) begin
                pkt_count_q <= pkt_count_q + 32'd1;
                ip_id_q     <= ip_id_q + 16'd1;
            end
        end
    end

    assign bus.axis_out_tkeep = {DATA_WBYTS{1'b1}};
    assign bus.len_err        = len_err_q;
    assign bus.pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_rdma_pkt_builder.sv
// Self-checking bench for rdma_pkt_builder: randomized payload/backpressure against a
// byte-array header model and a frame scoreboard.
module tb_rdma_pkt_builder;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rdma_pkt_builder_if #(.DATA_WBITS(512)) bus ();

    rdma_pkt_builder dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_id = 0;
    int unsigned exp_pkt = 0;
    logic [511:0] pay[$];
    logic [511:0] got_d[$];
    logic         got_l[$];
    int           pay_rdy_cycles;

    function automatic logic [511:0] exp_header(input int n, input logic [63:0] addr,
                                                input int id);
        logic [7:0]   b[64];
        int           w[9];
        int           ip_len, udp_len, sum, csum;
        logic [511:0] r;
        ip_len  = 50 + 64 * n;
        udp_len = 30 + 64 * n;
        w = '{'h4500, ip_len, id, 'h4000, 'h4011, 'h0A01, 'h0102, 'h0A01, 'h0101};
        sum = 0;
        foreach (w[i]) sum += w[i];
        while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
        csum = ~sum & 'hFFFF;
        foreach (b[k]) b[k] = 8'h00;
        b[0] = 8'h02; b[5] = 8'h01; b[6] = 8'h02; b[11] = 8'h02;
        b[12] = 8'h08;
        b[14] = 8'h45;
        b[16] = 8'(ip_len >> 8); b[17] = 8'(ip_len);
        b[18] = 8'(id >> 8);     b[19] = 8'(id);
        b[20] = 8'h40;
        b[22] = 8'h40; b[23] = 8'h11;
        b[24] = 8'(csum >> 8);   b[25] = 8'(csum);
        b[26] = 8'h0A; b[27] = 8'h01; b[28] = 8'h01; b[29] = 8'h02;
        b[30] = 8'h0A; b[31] = 8'h01; b[32] = 8'h01; b[33] = 8'h01;
        b[34] = 8'h2B; b[35] = 8'h67; b[36] = 8'h2B; b[37] = 8'h67;
        b[38] = 8'(udp_len >> 8); b[39] = 8'(udp_len);
        for (int i = 0; i < 8; i++) b[42+i] = addr[63-8*i -: 8];
        for (int k = 0; k < 64; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    function automatic logic [15:0] f16(input logic [511:0] d, input int k);
        return {d[8*k +: 8], d[8*k+8 +: 8]};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
        return d;
    endfunction

    task automatic idle_inputs();
        bus.req_addr        = '0;
        bus.req_beats       = '0;
        bus.req_valid       = 1'b0;
        bus.axis_pay_tdata  = '0;
        bus.axis_pay_tlast  = 1'b0;
        bus.axis_pay_tvalid = 1'b0;
        bus.axis_out_tready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn  = 1'b1;
        exp_id  = 0;
        exp_pkt = 0;
    endtask

    task automatic send_req(input int n, input logic [63:0] addr);
        int cyc;
        @(negedge clk);
        bus.req_addr  = addr;
        bus.req_beats = 8'(n);
        bus.req_valid = 1'b1;
        #1;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid       = 1'b0;
        bus.axis_out_tready = 1'b0;
        #1;
        n_checks++;
        if (bus.axis_out_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL calc_cycle_tvalid: got %b required 0", bus.axis_out_tvalid);
        end
    endtask

    task automatic run_frame(input int n, input logic [63:0] addr, input int tlast_beat,
                             input int stall_pct, input int gap_pct);
        int           pidx, cyc;
        bit           done, first, stalled, held;
        logic [511:0] prev_d, exp_hdr;
        logic         prev_l;
        pay.delete();
        got_d.delete();
        got_l.delete();
        for (int i = 0; i < n; i++) pay.push_back(rand512());
        pay_rdy_cycles = 0;
        send_req(n, addr);
        pidx = 0; cyc = 0; done = 0; first = 1; stalled = 0; held = 0;
        prev_d = '0; prev_l = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            bus.axis_out_tready = ($urandom_range(99) >= stall_pct);
            if (pidx < n && (held || $urandom_range(99) >= gap_pct)) begin
                bus.axis_pay_tvalid = 1'b1;
                bus.axis_pay_tdata  = pay[pidx];
                bus.axis_pay_tlast  = (pidx + 1 == tlast_beat);
            end else begin
                bus.axis_pay_tvalid = 1'b0;
                bus.axis_pay_tdata  = '0;
                bus.axis_pay_tlast  = 1'b0;
            end
            #1;
            if (first) begin
                n_checks++;
                if (bus.axis_out_tvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hdr_latency: tvalid=%b required 1 two cycles after request",
                             bus.axis_out_tvalid);
                end
                n_checks++;
                if (bus.axis_out_tkeep !== {64{1'b1}}) begin
                    n_fail++;
                    $display("FAIL tkeep: got %h required all ones", bus.axis_out_tkeep);
                end
                first = 0;
            end
            if (stalled) begin
                n_checks++;
                if (bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== prev_d ||
                    bus.axis_out_tlast !== prev_l) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b last=%b data=%h required held %b/%h",
                             bus.axis_out_tvalid, bus.axis_out_tlast, bus.axis_out_tdata,
                             prev_l, prev_d);
                end
            end
            if (bus.axis_pay_tready === 1'b1) pay_rdy_cycles++;
            stalled = bus.axis_out_tvalid && !bus.axis_out_tready;
            prev_d  = bus.axis_out_tdata;
            prev_l  = bus.axis_out_tlast;
            if (bus.axis_out_tvalid && bus.axis_out_tready) begin
                got_d.push_back(bus.axis_out_tdata);
                got_l.push_back(bus.axis_out_tlast);
                if (bus.axis_out_tlast) done = 1;
            end
            if (bus.axis_pay_tvalid && bus.axis_pay_tready) begin
                pidx++;
                held = 0;
            end else begin
                held = bus.axis_pay_tvalid;
            end
            cyc++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL frame_timeout: %0d beats seen, required %0d", got_d.size(), n + 1);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        exp_hdr = exp_header(n, addr, exp_id);
        exp_id  = (exp_id + 1) & 'hFFFF;
        exp_pkt++;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_req_ready: got %b required 1 after last beat", bus.req_ready);
        end
        n_checks++;
        if (bus.pkt_count !== exp_pkt) begin
            n_fail++;
            $display("FAIL pkt_count: got %0d required %0d", bus.pkt_count, exp_pkt);
        end
        n_checks++;
        if (got_d.size() != n + 1) begin
            n_fail++;
            $display("FAIL beat_count: got %0d required %0d", got_d.size(), n + 1);
        end
        if (got_d.size() > 0) begin
            n_checks++;
            if (got_d[0] !== exp_hdr) begin
                n_fail++;
                $display("FAIL header: got %h required %h", got_d[0], exp_hdr);
            end
        end
        for (int i = 1; i < got_d.size() && i <= n; i++) begin
            n_checks++;
            if (got_d[i] !== pay[i-1]) begin
                n_fail++;
                $display("FAIL payload[%0d]: got %h required %h", i - 1, got_d[i], pay[i-1]);
            end
        end
        for (int i = 0; i < got_l.size(); i++) begin
            n_checks++;
            if (got_l[i] !== (i == n)) begin
                n_fail++;
                $display("FAIL tlast[%0d]: got %b required %b", i, got_l[i], (i == n));
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.axis_pay_tready, bus.axis_out_tvalid, bus.axis_out_tlast,
             bus.len_err} !== 5'b0 || bus.pkt_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: rr=%b pr=%b ov=%b ol=%b le=%b pc=%0d required all 0",
                     bus.req_ready, bus.axis_pay_tready, bus.axis_out_tvalid,
                     bus.axis_out_tlast, bus.len_err, bus.pkt_count);
        end
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_header();
        logic [63:0] a;
        run_frame(1, 64'h0000_0001_2345_6780, 1, 0, 0);
        if (got_d.size() > 0) begin
            n_checks++;
            if (f16(got_d[0], 16) !== 16'h0072 || f16(got_d[0], 38) !== 16'h005E ||
                f16(got_d[0], 24) !== 16'h2477 || f16(got_d[0], 12) !== 16'h0800 ||
                f16(got_d[0], 36) !== 16'd11111) begin
                n_fail++;
                $display("FAIL hdr_fields: iplen=%h udplen=%h csum=%h etype=%h dport=%0d",
                         f16(got_d[0], 16), f16(got_d[0], 38), f16(got_d[0], 24),
                         f16(got_d[0], 12), f16(got_d[0], 36));
            end
            for (int i = 0; i < 8; i++) a[63-8*i -: 8] = got_d[0][8*(42+i) +: 8];
            n_checks++;
            if (a !== 64'h0000_0001_2345_6780) begin
                n_fail++;
                $display("FAIL hdr_addr: got %h required 0000000123456780", a);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1, 64'h0000_0001_2345_6780, 1, 0, 0);
        if (got_d.size() > 0) begin
            n_checks++;
            if (f16(got_d[0], 18) !== 16'h0001 || f16(got_d[0], 24) !== 16'h2476) begin
                n_fail++;
                $display("FAIL b2b_id_csum: id=%h csum=%h required 0001/2476",
                         f16(got_d[0], 18), f16(got_d[0], 24));
            end
        end
    endtask

    task automatic test_header_only();
        run_frame(0, {$urandom(), $urandom()}, 0, 30, 0);
        n_checks++;
        if (pay_rdy_cycles != 0) begin
            n_fail++;
            $display("FAIL hdr_only_pay_ready: asserted %0d cycles required 0", pay_rdy_cycles);
        end
        if (got_d.size() > 0) begin
            n_checks++;
            if (f16(got_d[0], 16) !== 16'h0032) begin
                n_fail++;
                $display("FAIL hdr_only_iplen: got %h required 0032", f16(got_d[0], 16));
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        run_frame(4, {$urandom(), $urandom()}, 4, 40, 40);
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 20);
            run_frame(n, {$urandom(), $urandom()}, n, $urandom_range(0, 60),
                      $urandom_range(0, 60));
        end
    endtask

    task automatic test_len_err();
        n_checks++;
        if (bus.len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_clean: got %b required 0", bus.len_err);
        end
        run_frame(3, {$urandom(), $urandom()}, 2, 20, 20);
        n_checks++;
        if (bus.len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_err_set: got %b required 1", bus.len_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_req(8, 64'hDEAD_BEEF_0000_1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.axis_out_tready = 1'b1;
            bus.axis_pay_tvalid = 1'b1;
            bus.axis_pay_tdata  = rand512();
        end
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.axis_out_tvalid !== 1'b0 || bus.pkt_count !== 32'd0 ||
            bus.len_err !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tvalid=%b pkt=%0d len_err=%b req_ready=%b required 0",
                     bus.axis_out_tvalid, bus.pkt_count, bus.len_err, bus.req_ready);
        end
        @(negedge clk);
        resetn  = 1'b1;
        exp_id  = 0;
        exp_pkt = 0;
        run_frame(1, 64'h0000_0001_2345_6780, 1, 0, 0);
        if (got_d.size() > 0) begin
            n_checks++;
            if (f16(got_d[0], 18) !== 16'h0000) begin
                n_fail++;
                $display("FAIL mid_reset_id: got %h required 0000", f16(got_d[0], 18));
            end
        end
    endtask

    task automatic test_carry_fold();
        apply_reset();
        run_frame(255, {$urandom(), $urandom()}, 255, 0, 0);
        if (got_d.size() > 0) begin
            n_checks++;
            if (f16(got_d[0], 16) !== 16'h3FF2 || f16(got_d[0], 24) !== 16'hE4F6) begin
                n_fail++;
                $display("FAIL carry_fold: iplen=%h csum=%h required 3FF2/E4F6",
                         f16(got_d[0], 16), f16(got_d[0], 24));
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_header();
        test_back_to_back();
        test_header_only();
        test_backpressure();
        test_len_err();
        test_reset_mid_frame();
        test_carry_fold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rdma_pkt_builder.md
Name: rdma_pkt_builder

Overview:
Transmit-side counterpart of the RDMA receive path. Accepts a send request (target address, payload beat count) plus a payload AXI-Stream, and emits a complete RDMA frame: one 64-byte header beat, then the payload beats.
- Header: Ethernet / IPv4 / UDP / 22-byte RDMA header, with IPv4 length, UDP length, IPv4 ID and IPv4 header checksum computed per packet.
- The output feeds the Ethernet MAC TX stream.

Parameters:
DATA_WBITS, 512, stream data width (block supports only 512)
DATA_WBYTS, DATA_WBITS/8, stream byte width
SRC_MAC, 48'h02_00_00_00_00_02, Ethernet source MAC
DST_MAC, 48'h02_00_00_00_00_01, Ethernet destination MAC
SRC_IP, 32'h0A01_0102, IPv4 source address
DST_IP, 32'h0A01_0101, IPv4 destination address
RDMA_SRC_PORT, 11111, UDP source port
RDMA_DEST_PORT, 11111, UDP destination port

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
REQ_ADDR  in  64  RDMA target address placed in header
REQ_BEATS  in  8  payload length in 64-byte beats, 0..255
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY
AXIS_PAY_TDATA  in  DATA_WBITS  payload data (full beats only)
AXIS_PAY_TLAST  in  1  payload end marker (checked, not used for framing)
AXIS_PAY_TVALID  in  1  payload valid
AXIS_PAY_TREADY  out  1  payload ready
AXIS_OUT_TDATA  out  DATA_WBITS  frame data
AXIS_OUT_TKEEP  out  DATA_WBYTS  always all ones
AXIS_OUT_TVALID  out  1  frame valid
AXIS_OUT_TLAST  out  1  last beat of frame
AXIS_OUT_TREADY  in  1  downstream ready
LEN_ERR  out  1  sticky: payload TLAST disagreed with REQ_BEATS
PKT_COUNT  out  32  frames fully sent since reset

Behaviour:
- Reset values: REQ_READY=0, AXIS_PAY_TREADY=0, AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, LEN_ERR=0, PKT_COUNT=0, IPv4 ID counter=0, state=IDLE.
- FSM states: IDLE, CALC, SEND_HDR, SEND_DATA.
- IDLE: REQ_READY=1. On handshake, latch REQ_ADDR and REQ_BEATS (N) and go to CALC.
- CALC (exactly 1 cycle): compute header fields.
  - ip4_length = 50 + 64*N; udp_length = 30 + 64*N (16-bit, no overflow for N<=255).
  - Checksum: 16-bit one's-complement sum of 0x4500, ip4_length, ip_id, 0x4000, 0x4011, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]. Fold carries until no carry remains, then invert.
  - Go to SEND_HDR.
- SEND_HDR: AXIS_OUT_TVALID=1 with the header beat; AXIS_OUT_TLAST = (N==0). On accept:
  - N==0: go to IDLE.
  - otherwise: go to SEND_DATA.
- Header layout, big-endian, header byte k on TDATA[8k+7:8k]:
  - dst MAC, src MAC, ethertype 0x0800
  - 0x4500, ip4_length, ip_id, 0x4000 (DF), 0x4011 (TTL 64, proto UDP), checksum, src IP, dst IP
  - src port, dst port, udp_length, UDP checksum 0x0000
  - REQ_ADDR (8 bytes), 14 reserved zero bytes
- SEND_DATA: pass-through.
  - AXIS_OUT_TDATA = AXIS_PAY_TDATA, AXIS_OUT_TVALID = AXIS_PAY_TVALID, AXIS_PAY_TREADY = AXIS_OUT_TREADY.
  - An internal beat counter advances on each transfer. AXIS_OUT_TLAST=1 on beat N.
  - On the final transfer: go to IDLE.
- Frame completion: when the beat carrying AXIS_OUT_TLAST is accepted, PKT_COUNT increments (wraps at 2^32) and ip_id increments (wraps 0xFFFF->0).
- Latency: request handshake at cycle t -> header TVALID at t+2. Back-to-back requests are accepted the cycle after the last beat transfers.
- AXIS_PAY_TREADY=0 outside SEND_DATA. Header and data are held stable while AXIS_OUT_TREADY=0.
- LEN_ERR: set if a transferred payload beat has TLAST=1 before beat N, or TLAST=0 on beat N. Framing always follows N. Cleared only by reset.
- Reset mid-frame: outputs drop to reset values at the next edge; the partial frame is abandoned.

Test Plan:
- Header check: N=1, REQ_ADDR=0x0000_0001_2345_6780, id=0 -> header fields are ip4_length 0x0072, udp_length 0x005E, checksum 0x2477, ethertype 0x0800, dst port 11111, REQ_ADDR in bytes 42..49. Then 1 payload beat with TLAST. PKT_COUNT=1.
- Back-to-back: second identical request -> id=1, checksum 0x2476. REQ_READY high the cycle after the prior TLAST transfer. Header TVALID 2 cycles after the request handshake.
- Checksum carry fold: N=255, id=0 -> ip4_length 0x3FF2, checksum 0xE4F6. Exactly 256 output beats; TLAST only on the last.
- Header-only: N=0 -> single beat with TLAST=1; AXIS_PAY_TREADY never asserted; ip4_length 0x0032.
- Backpressure: random AXIS_OUT_TREADY and AXIS_PAY_TVALID gaps, N=4 -> data order preserved, header stable while stalled, no beat lost or duplicated.
- Errors and reset:
  - N=3 with payload TLAST on beat 2 -> LEN_ERR=1; frame still 4 beats with TLAST on the final one.
  - Reset asserted mid-frame -> TVALID=0 and PKT_COUNT=0 after the edge; next frame uses id 0.
